// File: rtl/branch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : branch_pkg
// Description : Shared types and constants for the branch resolution unit.
//               Holds the branch type encoding, the conditional-type
//               classifier and the predictor counter reset value.
// Revision    : 1.0 - initial release
// ============================================================================
package branch_pkg;

    typedef enum logic [2:0] {
        BR_BEQ    = 3'd0,
        BR_BNE    = 3'd1,
        BR_BLT    = 3'd2,
        BR_BGE    = 3'd3,
        BR_BLTU   = 3'd4,
        BR_BGEU   = 3'd5,
        BR_NEVER  = 3'd6,
        BR_ALWAYS = 3'd7
    } br_type_e;

    // Weakly-not-taken for a counter of the given width: 2^(bits-1) - 1.
    function automatic int bht_weak_nt(input int bits);
        return (1 << (bits - 1)) - 1;
    endfunction

    // Weakly-not-taken value for the default 2-bit predictor counter.
    localparam logic [1:0] BHT_WEAK_NT = 2'(bht_weak_nt(2));

    // Only compare-based branches carry information worth training on.
    function automatic logic is_conditional(input br_type_e t);
        return (t == BR_BEQ)  || (t == BR_BNE)  || (t == BR_BLT) ||
               (t == BR_BGE)  || (t == BR_BLTU) || (t == BR_BGEU);
    endfunction

endpackage
`default_nettype wire

// File: rtl/branch_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : branch_unit_if
// Description : Resolve-side bundle between execute and the branch unit:
//               request operands/controls and the registered result.
// Revision    : 1.0 - initial release
// ============================================================================
interface branch_unit_if #(
    parameter int XLEN = 32
) ();

    logic                      res_valid_i;
    logic [XLEN-1:0]           res_pc_i;
    logic [XLEN-1:0]           rdata1_i;
    logic [XLEN-1:0]           rdata2_i;
    branch_pkg::br_type_e      br_type_i;
    logic [XLEN-1:0]           target_i;
    logic                      pred_taken_i;
    logic                      flush_i;

    logic                      out_valid_o;
    logic                      br_taken_o;
    logic                      mispredict_o;
    logic [XLEN-1:0]           redirect_pc_o;

    // Execute stage side: issues requests, consumes results.
    modport master (
        output res_valid_i, res_pc_i, rdata1_i, rdata2_i, br_type_i,
               target_i, pred_taken_i, flush_i,
        input  out_valid_o, br_taken_o, mispredict_o, redirect_pc_o
    );

    // Branch unit side.
    modport slave (
        input  res_valid_i, res_pc_i, rdata1_i, rdata2_i, br_type_i,
               target_i, pred_taken_i, flush_i,
        output out_valid_o, br_taken_o, mispredict_o, redirect_pc_o
    );

endinterface
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Up/down counter that saturates at zero and at all-ones.
//               Used for predictor entries and for statistics counters.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int               WIDTH     = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             en,
    input  wire logic             inc,
    output logic [WIDTH-1:0]      count
);

    // Step toward the requested direction unless already at that end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= RESET_VAL;
        end else if (en) begin
            if (inc && (count != '1)) begin
                count <= count + WIDTH'(1);
            end else if (!inc && (count != '0)) begin
                count <= count - WIDTH'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/branch_unit.sv
`default_nettype none
// ============================================================================
// Module      : branch_unit
// Description : Registered branch resolution with misprediction detection,
//               a direct-mapped table of saturating predictor counters read
//               by fetch, and saturating resolve/mispredict statistics.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_unit
    import branch_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int BHT_ENTRIES = 16,
    parameter int CTR_BITS    = 2,
    parameter int STAT_BITS   = 32
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic [XLEN-1:0]   pred_pc_i,
    output logic                   pred_taken_o,
    branch_unit_if.slave           res,
    output logic [STAT_BITS-1:0]   stat_branches_o,
    output logic [STAT_BITS-1:0]   stat_mispred_o
);

    localparam int                  IDX_W   = $clog2(BHT_ENTRIES);
    localparam logic [CTR_BITS-1:0] WEAK_NT = CTR_BITS'(bht_weak_nt(CTR_BITS));

    logic                  taken;
    logic                  accept;
    logic                  mispredict_next;
    logic                  bht_update;
    logic [XLEN-1:0]       redirect_next;
    logic [IDX_W-1:0]      res_idx;
    logic [IDX_W-1:0]      pred_idx;
    logic [CTR_BITS-1:0]   bht [BHT_ENTRIES];

    // Branch outcome from the operands and type, evaluated before the edge.
    always_comb begin
        taken = 1'b0;
        case (res.br_type_i)
            BR_BEQ:    taken = (res.rdata1_i == res.rdata2_i);
            BR_BNE:    taken = (res.rdata1_i != res.rdata2_i);
            BR_BLT:    taken = ($signed(res.rdata1_i) <  $signed(res.rdata2_i));
            BR_BGE:    taken = ($signed(res.rdata1_i) >= $signed(res.rdata2_i));
            BR_BLTU:   taken = (res.rdata1_i <  res.rdata2_i);
            BR_BGEU:   taken = (res.rdata1_i >= res.rdata2_i);
            BR_NEVER:  taken = 1'b0;
            BR_ALWAYS: taken = 1'b1;
            default:   taken = 1'b0;
        endcase
    end

    // A flush on the capture edge kills the request before it has any effect.
    assign accept          = res.res_valid_i && !res.flush_i;
    assign mispredict_next = taken != res.pred_taken_i;
    assign redirect_next   = taken ? res.target_i : (res.res_pc_i + XLEN'(4));
    assign bht_update      = accept && is_conditional(res.br_type_i);

    assign res_idx  = res.res_pc_i[IDX_W+1:2];
    assign pred_idx = pred_pc_i[IDX_W+1:2];

    // Result register; data holds on idle cycles, only the valid drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res.out_valid_o   <= 1'b0;
            res.br_taken_o    <= 1'b0;
            res.mispredict_o  <= 1'b0;
            res.redirect_pc_o <= '0;
        end else begin
            res.out_valid_o <= accept;
            if (accept) begin
                res.br_taken_o    <= taken;
                res.mispredict_o  <= mispredict_next;
                res.redirect_pc_o <= redirect_next;
            end
        end
    end

    // Predictor table: one saturating counter per entry, trained on outcome.
    for (genvar i = 0; i < BHT_ENTRIES; i++) begin : g_bht
        sat_counter #(
            .WIDTH     (CTR_BITS),
            .RESET_VAL (WEAK_NT)
        ) u_ctr (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (bht_update && (res_idx == IDX_W'(i))),
            .inc   (taken),
            .count (bht[i])
        );
    end

    // Fetch sees the stored value; an update on the same edge is not bypassed.
    assign pred_taken_o = bht[pred_idx][CTR_BITS-1];

    sat_counter #(
        .WIDTH     (STAT_BITS),
        .RESET_VAL ('0)
    ) u_stat_branches (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (accept),
        .inc   (1'b1),
        .count (stat_branches_o)
    );

    sat_counter #(
        .WIDTH     (STAT_BITS),
        .RESET_VAL ('0)
    ) u_stat_mispred (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (accept && mispredict_next),
        .inc   (1'b1),
        .count (stat_mispred_o)
    );

    // Only the index bits of the fetch PC select a predictor entry.
    logic unused_pred_pc;
    assign unused_pred_pc = ^{pred_pc_i[XLEN-1:IDX_W+2], pred_pc_i[1:0]};

endmodule
`default_nettype wire

// File: tb/tb_branch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_unit
// Description : Self-checking bench for branch_unit against a behavioural
//               model of outcome, redirect, predictor table and statistics.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_unit;
    import branch_pkg::*;

    localparam int XLEN = 32;
    localparam int ENT  = 16;
    localparam int CB   = 2;
    localparam int SB   = 4;
    localparam int CMAX = (1 << CB) - 1;
    localparam int SMAX = (1 << SB) - 1;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [31:0]     pred_pc = '0;
    logic            pred_taken;
    logic [SB-1:0]   st_br;
    logic [SB-1:0]   st_mp;

    branch_unit_if #(.XLEN(XLEN)) bif ();

    branch_unit #(
        .XLEN        (XLEN),
        .BHT_ENTRIES (ENT),
        .CTR_BITS    (CB),
        .STAT_BITS   (SB)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .pred_pc_i       (pred_pc),
        .pred_taken_o    (pred_taken),
        .res             (bif),
        .stat_branches_o (st_br),
        .stat_mispred_o  (st_mp)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference state
    int          m_ctr [ENT];
    int          m_br, m_mp;
    logic        m_valid, m_taken, m_misp;
    logic [31:0] m_redir;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc >> 2) % ENT);
    endfunction

    function automatic logic ref_taken(input int t, input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        sa = $signed(a);
        sb = $signed(b);
        case (t)
            0: return a == b;
            1: return a != b;
            2: return sa < sb;
            3: return sa >= sb;
            4: return a < b;
            5: return a >= b;
            7: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < ENT; i++) m_ctr[i] = (1 << (CB - 1)) - 1;
        m_br = 0; m_mp = 0;
        m_valid = 0; m_taken = 0; m_misp = 0; m_redir = '0;
    endfunction

    task automatic check_outputs();
        check("out_valid",  64'(bif.out_valid_o),   64'(m_valid));
        check("br_taken",   64'(bif.br_taken_o),    64'(m_taken));
        check("mispredict", 64'(bif.mispredict_o),  64'(m_misp));
        check("redirect",   64'(bif.redirect_pc_o), 64'(m_redir));
        check("stat_br",    64'(st_br),             64'(m_br));
        check("stat_mp",    64'(st_mp),             64'(m_mp));
    endtask

    // One clock: drive at negedge, check prediction before and results after the edge.
    task automatic step(input bit v, input bit fl, input logic [31:0] pc,
                        input logic [31:0] a, input logic [31:0] b, input int t,
                        input logic [31:0] tgt, input bit pt, input logic [31:0] ppc);
        logic tk;
        @(negedge clk);
        bif.res_valid_i  = v;
        bif.flush_i      = fl;
        bif.res_pc_i     = pc;
        bif.rdata1_i     = a;
        bif.rdata2_i     = b;
        bif.br_type_i    = br_type_e'(t[2:0]);
        bif.target_i     = tgt;
        bif.pred_taken_i = pt;
        pred_pc          = ppc;
        #1 check("pred_pre", 64'(pred_taken), 64'(m_ctr[idx_of(ppc)] >= (1 << (CB - 1))));
        @(posedge clk);
        if (v && !fl) begin
            tk      = ref_taken(t, a, b);
            m_valid = 1'b1;
            m_taken = tk;
            m_misp  = (tk != pt);
            m_redir = tk ? tgt : pc + 32'd4;
            if (t <= 5) begin
                if (tk) m_ctr[idx_of(pc)] = (m_ctr[idx_of(pc)] < CMAX) ? m_ctr[idx_of(pc)] + 1 : CMAX;
                else    m_ctr[idx_of(pc)] = (m_ctr[idx_of(pc)] > 0)    ? m_ctr[idx_of(pc)] - 1 : 0;
            end
            m_br = (m_br < SMAX) ? m_br + 1 : SMAX;
            if (m_misp) m_mp = (m_mp < SMAX) ? m_mp + 1 : SMAX;
        end else begin
            m_valid = 1'b0;
        end
        #1;
        check_outputs();
        check("pred_post", 64'(pred_taken), 64'(m_ctr[idx_of(ppc)] >= (1 << (CB - 1))));
    endtask

    // Asynchronous reset asserted between clock edges, checked before any edge.
    task automatic async_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 model_reset();
        check_outputs();
        check("pred_rst", 64'(pred_taken), 64'(0));
        bif.res_valid_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] a, b, pc;
        bif.res_valid_i = 0; bif.flush_i = 0; bif.res_pc_i = '0; bif.rdata1_i = '0;
        bif.rdata2_i = '0; bif.br_type_i = BR_BEQ; bif.target_i = '0; bif.pred_taken_i = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 check_outputs();
        @(negedge clk);
        rst_n = 1'b1;

        // Compare matrix with -1 vs 1
        for (int t = 0; t < 8; t++)
            step(1, 0, 32'h1000, 32'hFFFF_FFFF, 32'd1, t, 32'h2000, 0, 32'h1000);

        // Redirect, mispredict and PC wrap
        async_reset();
        step(1, 0, 32'h100, 32'd5, 32'd5, 0, 32'h200, 0, 32'h0);
        check("redir_taken", 64'(bif.redirect_pc_o), 64'h200);
        check("misp_taken",  64'(bif.mispredict_o),  64'd1);
        check("stat_mp_one", 64'(st_mp),             64'd1);
        step(1, 0, 32'h100, 32'd5, 32'd6, 0, 32'h200, 0, 32'h0);
        check("redir_nt",    64'(bif.redirect_pc_o), 64'h104);
        check("misp_nt",     64'(bif.mispredict_o),  64'd0);
        step(1, 0, 32'hFFFF_FFFC, 32'd1, 32'd2, 0, 32'h200, 0, 32'h0);
        check("redir_wrap",  64'(bif.redirect_pc_o), 64'h0);

        // Predictor training, collision and aliasing at index of 0x40
        async_reset();
        step(0, 0, 32'h0, 32'd0, 32'd0, 0, 32'h0, 0, 32'h40);
        check("pred_init", 64'(pred_taken), 64'd0);
        for (int i = 0; i < 3; i++) step(1, 0, 32'h40, 32'd1, 32'd2, 1, 32'h80, 0, 32'h40);
        check("pred_trained", 64'(pred_taken), 64'd1);
        for (int i = 0; i < 4; i++) step(1, 0, 32'h40, 32'd3, 32'd3, 1, 32'h80, 1, 32'h40);
        check("pred_untrained", 64'(pred_taken), 64'd0);
        for (int i = 0; i < 2; i++) step(1, 0, 32'h80, 32'd1, 32'd2, 1, 32'h80, 0, 32'h40);
        check("pred_alias", 64'(pred_taken), 64'd1);

        // Flush drops the request entirely
        step(1, 1, 32'h40, 32'd3, 32'd3, 1, 32'h80, 1, 32'h40);
        check("flush_valid", 64'(bif.out_valid_o), 64'd0);

        // Back-to-back then reset mid-stream
        async_reset();
        for (int i = 0; i < 5; i++) step(1, 0, 32'h40 + 32'(i * 4), 32'(i), 32'd2, 2, 32'h300, 1, 32'h40);
        check("b2b_count", 64'(st_br), 64'd5);
        async_reset();
        step(0, 0, 32'h0, 32'd0, 32'd0, 0, 32'h0, 0, 32'h40);

        // Statistics saturation
        for (int i = 0; i < 20; i++) step(1, 0, 32'h10, 32'd0, 32'd0, 7, 32'h20, 0, 32'h10);
        check("stat_sat", 64'(st_br), 64'(SMAX));

        // Randomised traffic
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 99) == 0) async_reset();
            a  = $urandom;
            case ($urandom_range(0, 3))
                0: b = a;
                1: b = $urandom_range(0, 3);
                default: b = $urandom;
            endcase
            case ($urandom_range(0, 3))
                0: pc = 32'h40;
                1: pc = 32'h80;
                2: pc = 32'hFFFF_FFFC;
                default: pc = $urandom & 32'hFFFF_FFFC;
            endcase
            step($urandom_range(0, 4) != 0, $urandom_range(0, 9) == 0, pc, a, b,
                 int'($urandom_range(0, 7)), $urandom & 32'hFFFF_FFFC,
                 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 1) == 1) ? pc : ($urandom & 32'hFFFF_FFFC));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/branch_unit.md
Name: branch_unit

Overview:
- Parametrised, registered branch-resolution unit and the successor to the single-cycle combinational branch comparator.
- Resolves all conditional and unconditional branch types, computes the redirect PC and flags mispredictions against a fetch-side prediction.
- Trains a direct-mapped table of saturating counters that the fetch stage reads for prediction.
- Keeps saturating statistics counters; sits between execute (resolve side) and fetch (predict side).

Parameters:
- XLEN, 32, datapath and PC width.
- BHT_ENTRIES, 16, number of predictor counters (power of 2, min 2).
- CTR_BITS, 2, width of each saturating counter (min 2).
- STAT_BITS, 32, width of statistics counters.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- pred_pc_i  in  XLEN  fetch PC to predict.
- pred_taken_o  out  1  combinational prediction = MSB of indexed counter.
- res_valid_i  in  1  resolve request valid (single-cycle pulse per branch).
- res_pc_i  in  XLEN  PC of the branch being resolved.
- rdata1_i, rdata2_i  in  XLEN  source operands.
- br_type_i  in  3  branch type (br_type_e).
- target_i  in  XLEN  precomputed taken target.
- pred_taken_i  in  1  prediction that fetch used for this branch.
- flush_i  in  1  cancel the request in flight.
- out_valid_o  out  1  result valid, one cycle after res_valid_i.
- br_taken_o  out  1  resolved outcome.
- mispredict_o  out  1  br_taken_o != registered pred_taken_i; valid only with out_valid_o.
- redirect_pc_o  out  XLEN  taken ? target : pc+4 (mod 2^XLEN).
- stat_branches_o  out  STAT_BITS  resolved branch count.
- stat_mispred_o  out  STAT_BITS  misprediction count.

Behaviour:
- Reset (async, rst_n=0):
  - out_valid_o, br_taken_o and mispredict_o = 0; redirect_pc_o = 0.
  - Both stat counters = 0.
  - All BHT counters = weakly-not-taken (2^(CTR_BITS-1) - 1, i.e. 01 for 2 bits).
  - Reset asserted mid-operation discards the in-flight result; out_valid_o is 0 on the first edge after release.
- Outcome, computed combinationally from inputs:
  - BEQ: eq.
  - BNE: ne.
  - BLT / BGE: signed compare.
  - BLTU / BGEU: unsigned compare.
  - NEVER: 0.
  - ALWAYS: 1.
  - Undefined encodings: 0.
- Latency 1:
  - On a rising edge with res_valid_i=1 and flush_i=0, register br_taken_o, mispredict_o and redirect_pc_o; out_valid_o=1 for exactly one cycle.
  - res_valid_i=0 gives out_valid_o=0 next cycle; data outputs hold their last value.
  - Back-to-back requests every cycle are supported; no stall, no ready.
- Flush:
  - flush_i=1 on the same edge as res_valid_i: request is dropped entirely (out_valid_o=0, no BHT or stat update).
  - flush_i has no effect on an already-registered output.
- BHT index = res_pc_i / pred_pc_i bits [log2(BHT_ENTRIES)+1:2].
- BHT update on an accepted request with a conditional type (BEQ..BGEU) only:
  - Taken: increment, saturating at all-ones.
  - Not taken: decrement, saturating at 0.
  - NEVER, ALWAYS and undefined types do not touch the BHT.
- Read/update collision: the predict read in the same cycle as an update of the same index returns the pre-update value. There is no bypass.
- Statistics:
  - stat_branches_o increments on every accepted request.
  - stat_mispred_o increments on every accepted request whose mispredict is 1.
  - Both saturate at all-ones; they never wrap.
- redirect_pc_o uses XLEN-bit wrap: pc = 2^XLEN - 4, not taken → 0.

Decomposition:
- Package branch_pkg holds:
  - typedef enum logic [2:0] br_type_e: BR_BEQ=0, BR_BNE=1, BR_BLT=2, BR_BGE=3, BR_BLTU=4, BR_BGEU=5, BR_NEVER=6, BR_ALWAYS=7.
  - Function is_conditional().
  - Constant BHT_WEAK_NT.
- One sub-module, sat_counter (parametrised width, inc/dec/en, saturating). It is instantiated for the BHT entries and reused, with width STAT_BITS, for the statistics counters.

Test Plan:
- Compare matrix:
  - rdata1=0xFFFFFFFF, rdata2=1 for each type → BLT=1, BLTU=0, BGE=0, BGEU=1, BEQ=0, BNE=1.
  - NEVER=0, ALWAYS=1, all with out_valid_o one cycle later.
- Redirect and mispredict:
  - BEQ, pc=0x100, target=0x200, equal operands, pred_taken_i=0 → redirect 0x200, mispredict=1, stat_mispred_o=1.
  - Same with unequal operands → redirect 0x104, mispredict=0.
  - Wrap case: pc=0xFFFFFFFC not taken → redirect 0x0.
- BHT training:
  - After reset, pred_pc_i=0x40 → pred_taken_o=0.
  - Three taken BNE at pc=0x40 → counter 01→10→11→11 (pred_taken_o=1 after the first).
  - Four not-taken → saturates at 00.
  - pc=0x80 (same index with 16 entries) aliases.
- Collision and flush:
  - Update and predict read of the same index on the same edge → pred_taken_o shows the old value that cycle.
  - res_valid_i with flush_i=1 → out_valid_o=0, counters and stats unchanged.
- Back-to-back and reset:
  - 5 consecutive valid cycles → 5 consecutive out_valid_o pulses, stat_branches_o=5.
  - Assert rst_n=0 asynchronously mid-stream → outputs and stats 0 immediately, BHT back to 01.
- Saturation: with STAT_BITS=4, 20 requests → stat_branches_o holds at 15.
